ram_arbiter: RTL and testbench

- Two-port arbiter and access sequencer for the bus-attached RAM (address register loaded by LDRAMD, array strobed by LDRAM/we).
- Port 0 (CPU) and port 1 (loader/DMA) issue single-word read or write requests; the block grants one at a time using round-robin.
- For the granted port it drives the address, then the data, onto the shared bus and pulses LDRAMD, then LDRAM.
- Returns read data and a one-cycle done pulse to the requester.

---
 rtl/ram_arbiter.sv | 135 +++++++++++++
 tb/tb_ram_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter that sequences one single-word access at a time from two ports onto the shared RAM bus.
// Bus and strobes launch on the falling edge, so the RAM's clock-gated registers each see one clean pulse.
module ram_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             wr0,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             done0,
  output logic [WIDTH-1:0] rdata0,
  input  logic             req1,
  input  logic             wr1,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             done1,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output logic             LDRAMD,
  output logic             LDRAM,
  output logic             we,
  input  logic [WIDTH-1:0] ram_q,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_ACCESS,
    S_CAPTURE
  } state_t;

  state_t           r_state;
  logic             r_ptr;
  logic             r_port;
  logic             r_wr;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;

  logic w_elig0;
  logic w_elig1;
  logic w_both;
  logic w_sel1;

  // A port whose done is showing is skipped, so dropping req on done never causes a repeat access.
  assign w_elig0 = req0 & ~done0;
  assign w_elig1 = req1 & ~done1;
  assign w_both  = w_elig0 & w_elig1;
  assign w_sel1  = w_both ? r_ptr : w_elig1;
  assign busy    = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_port  <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_elig0 || w_elig1) begin
            r_port  <= w_sel1;
            r_wr    <= w_sel1 ? wr1 : wr0;
            r_addr  <= w_sel1 ? addr1 : addr0;
            r_wdata <= w_sel1 ? wdata1 : wdata0;
            if (w_both) begin
              r_ptr <= ~r_ptr;
            end
            r_state <= S_ADDR;
          end
        end
        S_ADDR:   r_state <= S_ACCESS;
        S_ACCESS: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_state <= S_IDLE;
          if (r_port) begin
            done1 <= 1'b1;
            if (!r_wr) begin
              rdata1 <= ram_q;
            end
          end else begin
            done0 <= 1'b1;
            if (!r_wr) begin
              rdata0 <= ram_q;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Decoded from the state the next rising edge will act on, held across that edge's high phase.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_out <= '0;
      bus_oe  <= 1'b0;
      LDRAMD  <= 1'b0;
      LDRAM   <= 1'b0;
      we      <= 1'b0;
    end else begin
      bus_out <= '0;
      bus_oe  <= 1'b0;
      LDRAMD  <= 1'b0;
      LDRAM   <= 1'b0;
      we      <= 1'b0;
      case (r_state)
        S_ADDR: begin
          bus_out <= r_addr;
          bus_oe  <= 1'b1;
          LDRAMD  <= 1'b1;
        end
        S_ACCESS: begin
          bus_out <= r_wdata;
          bus_oe  <= 1'b1;
          LDRAM   <= 1'b1;
          we      <= r_wr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural RAM on the bus plus a transaction-level reference model
// predicting grants, strobe timing, done pulses and read data from the arbitration rules.
module tb_ram_arbiter;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0, wr0, req1, wr1;
  logic [WIDTH-1:0] addr0, wdata0, addr1, wdata1;
  logic             done0, done1;
  logic [WIDTH-1:0] rdata0, rdata1;
  logic [WIDTH-1:0] bus_out, ram_q;
  logic             bus_oe, LDRAMD, LDRAM, we, busy;

  ram_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .done0(done0), .rdata0(rdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .done1(done1), .rdata1(rdata1),
    .bus_out(bus_out), .bus_oe(bus_oe), .LDRAMD(LDRAMD), .LDRAM(LDRAM), .we(we),
    .ram_q(ram_q), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM: address register loaded by LDRAMD, array strobed by LDRAM, read data straight from the array.
  logic [WIDTH-1:0] ramMem [0:255] = '{default: '0};
  logic [7:0]       ramAddr = '0;
  logic [7:0]       ramRdAddr = '0;

  always @(posedge clk) begin
    if (LDRAMD) ramAddr <= bus_out[7:0];
    if (LDRAM) begin
      if (we) ramMem[ramAddr] <= bus_out;
      ramRdAddr <= ramAddr;
    end
  end
  assign ram_q = ramMem[ramRdAddr];

  int               cyc, checks, errors, lastGrant, done0Count, ldramCount;
  bit               ptr, lastPort, lastWr;
  logic [WIDTH-1:0] lastAddr, lastWdata, expRd0, expRd1;
  logic [WIDTH-1:0] refMem [0:255] = '{default: '0};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic modelReset();
    lastGrant = -100;
    ptr       = 1'b0;
    lastPort  = 1'b0;
    lastWr    = 1'b0;
    lastAddr  = '0;
    lastWdata = '0;
    expRd0    = '0;
    expRd1    = '0;
  endtask

  // Decide what the rising edge ending the current cycle grants; a transaction occupies four edges.
  task automatic modelEdge();
    int nxt  = cyc + 1;
    bit doneNow = (nxt == lastGrant + 4);
    bit e0 = req0 && !(doneNow && !lastPort);
    bit e1 = req1 && !(doneNow && lastPort);
    bit g;
    if (nxt >= lastGrant + 4 && (e0 || e1)) begin
      if (e0 && e1) begin
        g   = ptr;
        ptr = !ptr;
      end else begin
        g = e1;
      end
      lastGrant = nxt;
      lastPort  = g;
      lastWr    = g ? wr1 : wr0;
      lastAddr  = g ? addr1 : addr0;
      lastWdata = g ? wdata1 : wdata0;
    end
  endtask

  // Expected outputs follow from how many cycles have passed since the last grant.
  task automatic checkCycle();
    int         ph = cyc - lastGrant;
    logic [6:0] expCtrl = '0;
    logic [WIDTH-1:0] expBus = '0;
    bit         chkBus = 1'b0;
    case (ph)
      0: begin expCtrl = 7'b0011100; expBus = lastAddr; chkBus = 1'b1; end
      1: begin expCtrl = {4'b0011, 1'b0, 1'b1, lastWr}; expBus = lastWdata; chkBus = 1'b1; end
      2: expCtrl = 7'b0010000;
      3: begin
        expCtrl = {!lastPort, lastPort, 5'b00000};
        if (lastWr) refMem[lastAddr[7:0]] = lastWdata;
        else if (lastPort) expRd1 = refMem[lastAddr[7:0]];
        else expRd0 = refMem[lastAddr[7:0]];
      end
      default: ;
    endcase
    checkOutput("ctrl", 32'({done0, done1, busy, bus_oe, LDRAMD, LDRAM, we}), 32'(expCtrl));
    if (chkBus) checkOutput("bus", 32'(bus_out), 32'(expBus));
    checkOutput("rdata0", 32'(rdata0), 32'(expRd0));
    checkOutput("rdata1", 32'(rdata1), 32'(expRd1));
    if (done0) done0Count++;
    if (LDRAM) ldramCount++;
  endtask

  task automatic applyStimulus(input bit r0, input bit w0, input logic [WIDTH-1:0] a0,
                               input logic [WIDTH-1:0] d0, input bit r1, input bit w1,
                               input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] d1);
    req0 = r0; wr0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; wr1 = w1; addr1 = a1; wdata1 = d1;
    modelEdge();
    @(negedge clk);
    #1;
    cyc++;
    checkCycle();
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic waitDone(input bit port, input string tag, output int n);
    n = 0;
    while (!(port ? done1 : done0) && n < 10) begin
      idleCycles(1);
      n++;
    end
    checkOutput(tag, 32'(port ? done1 : done0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int base;
    bit sawDone, dropNow, rr0, rr1;
    checks = 0; errors = 0; done0Count = 0; ldramCount = 0; cyc = 0;
    rst_n = 1'b0;
    req0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_bus", 32'(bus_out), 32'd0);
    checkCycle();
    rst_n = 1'b1;

    $display("[TB] port 0 write 0x0010 <= 0xBEEF");
    applyStimulus(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, '0, '0);
    waitDone(1'b0, "done0_wait", lat);
    checkOutput("done0_latency", 32'(lat), 32'd3);
    idleCycles(2);

    $display("[TB] port 1 read 0x0010");
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0010, 16'h1234);
    waitDone(1'b1, "done1_wait", lat);
    checkOutput("rd1_beef", 32'(rdata1), 32'h0000BEEF);
    checkOutput("rd0_hold", 32'(rdata0), 32'd0);
    idleCycles(2);

    $display("[TB] both ports requesting continuously");
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom),
                    1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom));
    idleCycles(6);

    $display("[TB] single port, three back-to-back transactions");
    base = done0Count;
    for (int i = 0; i < 11; i++)
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom),
                    1'b0, 1'b0, '0, '0);
    idleCycles(6);
    checkOutput("three_done0", 32'(done0Count - base), 32'd3);

    $display("[TB] requester drops req0 the cycle after done0");
    base = ldramCount; sawDone = 0; dropNow = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(!dropNow, 1'b1, 16'h0020, 16'h5555, 1'b0, 1'b0, '0, '0);
      dropNow = sawDone;
      if (done0) sawDone = 1'b1;
    end
    checkOutput("one_access", 32'(ldramCount - base), 32'd1);

    $display("[TB] reset during ACCESS");
    applyStimulus(1'b1, 1'b1, 16'h0030, 16'h1111, 1'b0, 1'b0, '0, '0);
    waitDone(1'b0, "prewrite_done", lat);
    idleCycles(2);
    applyStimulus(1'b1, 1'b1, 16'h0030, 16'hAAAA, 1'b0, 1'b0, '0, '0);
    idleCycles(1);
    checkOutput("ldram_before_rst", 32'(LDRAM), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_abort_ctrl", 32'({done0, done1, busy, bus_oe, LDRAMD, LDRAM, we}), 32'd0);
    checkOutput("rst_abort_bus", 32'(bus_out), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    cyc = 0;
    checkCycle();
    idleCycles(6);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0030, '0);
    waitDone(1'b1, "abort_read_done", lat);
    checkOutput("abort_nowrite", 32'(rdata1), 32'h00001111);
    idleCycles(2);

    $display("[TB] randomized traffic");
    rr0 = 0; rr1 = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rr0 = !rr0;
      if ($urandom_range(0, 3) == 0) rr1 = !rr1;
      applyStimulus(rr0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom),
                    rr1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom));
    end
    idleCycles(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
